// File: rtl/spike_enc_pkg.sv
// Shared definitions for the spike rate encoder: run states, rate width and
// the LFSR constants used by the stochastic build (SPIKE_ENC_STOCHASTIC_EN).
package spike_enc_pkg;

  localparam int RATE_W = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Rotate left by amt (mod 16); gives each channel its own view of the LFSR.
  function automatic logic [15:0] rotl16(input logic [15:0] val, input int unsigned amt);
    int unsigned sh;
    sh = amt % 16;
    if (sh == 0) return val;
    return (val << sh) | (val >> (16 - sh));
  endfunction

endpackage

// File: rtl/spike_phase_acc.sv
// One channel of the spike rate encoder.
// Default build: 8-bit phase accumulator whose carry-out is the spike bit.
// With SPIKE_ENC_STOCHASTIC_EN: stateless comparator of a random byte against
// the rate.
module spike_phase_acc
  import spike_enc_pkg::*;
(
`ifdef SPIKE_ENC_STOCHASTIC_EN
  input  logic [RATE_W-1:0] rate,
  input  logic [7:0]        rnd_byte,
  output logic              spike
`else
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RATE_W-1:0] rate,
  input  logic              tick_en,
  input  logic              clear,
  output logic              spike
`endif
);

`ifdef SPIKE_ENC_STOCHASTIC_EN

  assign spike = (rnd_byte < rate);

`else

  logic [RATE_W-1:0] acc_q;
  logic [RATE_W:0]   sum;

  // The carry of acc + rate is the spike; the low byte is the new phase.
  assign sum   = {1'b0, acc_q} + {1'b0, rate};
  assign spike = sum[RATE_W];

  // Phase register: cleared on a new run, advanced only on ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (tick_en) begin
      acc_q <= sum[RATE_W-1:0];
    end
  end

`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes per-channel 8-bit intensities into parallel spike trains.
// Holds the run FSM, tick prescaler, tick counter, rate registers and the
// registered tick/spike outputs; one spike_phase_acc per channel.
// Optional feature macro: SPIKE_ENC_STOCHASTIC_EN (LFSR-based spike source).
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int PRESCALE_W = 8,
  parameter int AW         = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [RATE_W-1:0]     wr_data,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            window,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  tick,
  output logic [CHANNELS-1:0]   spikes
);

  enc_state_t state_q, state_d;

  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [7:0]            window_q;
  logic [7:0]            tick_cnt;
  logic [RATE_W-1:0]     rate_q [CHANNELS];

  logic                  tick_q;
  logic [CHANNELS-1:0]   spikes_q;
  logic [CHANNELS-1:0]   spike_bits;

  logic start_acc;
  logic fire;
  logic last_tick;

  // A start is only honoured outside RUN; a tick fires when the prescaler
  // reaches its latched period. Window 0 wraps to 255 and so means 256 ticks.
  assign start_acc = start && (state_q != ST_RUN);
  assign fire      = (state_q == ST_RUN) && ena && (presc_cnt == prescale_q);
  assign last_tick = fire && (tick_cnt == (window_q - 8'd1));

  // Run state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE/DONE start a run, RUN ends on the final tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_RUN;
      ST_RUN:  if (last_tick) state_d = ST_DONE;
      ST_DONE: if (start_acc) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched run parameters, prescaler and tick counter; all hold while ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      window_q   <= '0;
      presc_cnt  <= '0;
      tick_cnt   <= '0;
    end else if (start_acc) begin
      prescale_q <= prescale;
      window_q   <= window;
      presc_cnt  <= '0;
      tick_cnt   <= '0;
    end else if (fire) begin
      presc_cnt  <= '0;
      tick_cnt   <= tick_cnt + 8'd1;
    end else if ((state_q == ST_RUN) && ena) begin
      presc_cnt  <= presc_cnt + PRESCALE_W'(1);
    end
  end

  // Rate register file; writable in any state, a write landing on a tick edge
  // only affects later ticks because the tick samples the current contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) rate_q[c] <= '0;
    end else if (wr_en) begin
      rate_q[wr_addr] <= wr_data;
    end
  end

  // Registered outputs: tick and spikes are high for exactly the cycle after
  // a tick edge and zero at every other time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= 1'b0;
      spikes_q <= '0;
    end else begin
      tick_q   <= fire;
      spikes_q <= fire ? spike_bits : '0;
    end
  end

`ifdef SPIKE_ENC_STOCHASTIC_EN

  logic [15:0] lfsr_q;

  // Shared random source: reseeded per run, stepped after each tick samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (start_acc) begin
      lfsr_q <= LFSR_SEED;
    end else if (fire) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [15:0] rot;
    assign rot = rotl16(lfsr_q, c);
    spike_phase_acc u_acc (
      .rate     (rate_q[c]),
      .rnd_byte (rot[7:0]),
      .spike    (spike_bits[c])
    );
  end

`else

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    spike_phase_acc u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .rate    (rate_q[c]),
      .tick_en (fire),
      .clear   (start_acc),
      .spike   (spike_bits[c])
    );
  end

`endif

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign tick   = tick_q;
  assign spikes = spikes_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder (default deterministic build).
module tb_spike_rate_encoder;

  localparam int CH = 8;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    prescale;
  logic [7:0]    window;
  logic          start;
  logic          busy;
  logic          done;
  logic          tick;
  logic [CH-1:0] spikes;

  spike_rate_encoder #(.CHANNELS(CH), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .prescale (prescale),
    .window   (window),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .tick     (tick),
    .spikes   (spikes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;

  // Run log gathered on falling edges.
  int            cyc;
  int            busy_cnt;
  int            stray;
  logic [CH-1:0] spk_log[$];
  int            cyc_log[$];
  logic          done_log[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tick === 1'b1) begin
      spk_log.push_back(spikes);
      cyc_log.push_back(cyc);
      done_log.push_back(done);
    end else if (spikes !== '0) begin
      stray = stray + 1;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  typedef struct {
    logic [7:0] r0, r1, r7;
    logic [7:0] pre, win;
    int exp_ticks, exp_s0, exp_s1, exp_s7, exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearLog();
    cyc = 0; busy_cnt = 0; stray = 0;
    spk_log.delete(); cyc_log.delete(); done_log.delete();
  endtask

  function automatic int countCh(input int c);
    int n = 0;
    foreach (spk_log[i]) n += int'(spk_log[i][c]);
    return n;
  endfunction

  task automatic writeRate(input int c, input logic [7:0] v);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'(c); wr_data = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Returns just after the start edge E0, with the log cleared at that point.
  task automatic startRun(input logic [7:0] p, input logic [7:0] w);
    @(posedge clk); #1;
    prescale = p; window = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clearLog();
  endtask

  // Waits for done with a cycle budget, then lets the final tick get logged.
  task automatic waitDone(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_within_budget", int'(done === 1'b1), 1);
    @(negedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    writeRate(0, v.r0);
    writeRate(1, v.r1);
    writeRate(7, v.r7);
    startRun(v.pre, v.win);
    waitDone(4000);
  endtask

  initial begin
    logic [7:0]    exp0, exp1;
    logic [CH-1:0] spk_a[$];
    int            cyc_a[$];
    int            bad;
    int            nlog;

    n_compared = 0; n_mismatched = 0;
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    prescale = '0; window = '0; start = 1'b0;
    clearLog();

    //            r0     r1     r7     pre   win    ticks s0   s1  s7   busy
    vecs[0] = '{8'd0,   8'd0,  8'd0,   8'd0, 8'd4,  4,    0,   0,  0,   4};
    vecs[1] = '{8'd128, 8'd64, 8'd0,   8'd0, 8'd8,  8,    4,   2,  0,   8};
    vecs[2] = '{8'd128, 8'd64, 8'd255, 8'd3, 8'd0,  256,  128, 64, 255, 1024};
    vecs[3] = '{8'd1,   8'd3,  8'd200, 8'd1, 8'd0,  256,  1,   3,  200, 512};
    vecs[4] = '{8'd100, 8'd255,8'd17,  8'd2, 8'd10, 10,   3,   9,  0,   30};

    // Reset state and 20 idle clocks.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clearLog();
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_done", int'(done), 0);
    checkOutput("idle_tick", int'(tick), 0);
    checkOutput("idle_spikes", int'(spikes), 0);
    checkOutput("idle_tick_count", spk_log.size(), 0);
    checkOutput("idle_busy_cycles", busy_cnt, 0);

    // Table-driven runs.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      $display("[TB] vector %0d: %0d ticks", i, spk_log.size());
      checkOutput($sformatf("v%0d_ticks", i), spk_log.size(), vecs[i].exp_ticks);
      checkOutput($sformatf("v%0d_ch0", i), countCh(0), vecs[i].exp_s0);
      checkOutput($sformatf("v%0d_ch1", i), countCh(1), vecs[i].exp_s1);
      checkOutput($sformatf("v%0d_ch7", i), countCh(7), vecs[i].exp_s7);
      checkOutput($sformatf("v%0d_other_ch", i),
                  countCh(2) + countCh(3) + countCh(4) + countCh(5) + countCh(6), 0);
      checkOutput($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_stray_spikes", i), stray, 0);
      checkOutput($sformatf("v%0d_done", i), int'(done), 1);
      checkOutput($sformatf("v%0d_busy_end", i), int'(busy), 0);
      if (cyc_log.size() >= 2) begin
        checkOutput($sformatf("v%0d_first_tick_cyc", i), cyc_log[0], int'(vecs[i].pre) + 2);
        checkOutput($sformatf("v%0d_tick_spacing", i), cyc_log[1] - cyc_log[0], int'(vecs[i].pre) + 1);
      end
    end

    // done holds in DONE, then a back-to-back start clears it immediately.
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_hold", int'(done), 1);
    checkOutput("done_hold_busy", int'(busy), 0);
    checkOutput("done_hold_tick", int'(tick), 0);
    startRun(8'd0, 8'd4);
    checkOutput("b2b_done_cleared", int'(done), 0);
    checkOutput("b2b_busy", int'(busy), 1);
    waitDone(100);

    // Tick positions for rate 128 / 64.
    applyStimulus(vecs[1]);
    exp0 = 8'b1010_1010;
    exp1 = 8'b1000_1000;
    checkOutput("pos_tick_count", spk_log.size(), 8);
    nlog = (spk_log.size() < 8) ? spk_log.size() : 8;
    bad = 0;
    for (int k = 0; k < nlog; k++) begin
      if (spk_log[k][0] !== exp0[k]) bad++;
      if (spk_log[k][1] !== exp1[k]) bad++;
    end
    checkOutput("pos_pattern_errors", bad, 0);
    if (nlog == 8) begin
      checkOutput("pos_done_at_tick8", int'(done_log[7]), 1);
      checkOutput("pos_done_before_tick8", int'(done_log[6]), 0);
    end

    // Reference run, then the same run frozen by ena for 10 clocks with a
    // spurious start in the middle.
    applyStimulus('{8'd100, 8'd37, 8'd200, 8'd1, 8'd12, 12, 4, 1, 9, 24});
    checkOutput("ref_ticks", spk_log.size(), 12);
    checkOutput("ref_ch0", countCh(0), 4);
    checkOutput("ref_ch1", countCh(1), 1);
    checkOutput("ref_ch7", countCh(7), 9);
    spk_a = spk_log;
    cyc_a = cyc_log;
    startRun(8'd1, 8'd12);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b0;
    repeat (10) @(posedge clk);
    #1 ena = 1'b1;
    waitDone(200);
    checkOutput("ena_ticks", spk_log.size(), 12);
    checkOutput("ena_ch0", countCh(0), 4);
    checkOutput("ena_ch7", countCh(7), 9);
    checkOutput("ena_busy_cycles", busy_cnt, 34);
    checkOutput("ena_stray_spikes", stray, 0);
    bad = 0;
    if (spk_log.size() == spk_a.size()) begin
      foreach (spk_a[i]) begin
        if (spk_log[i] !== spk_a[i]) bad++;
        if (cyc_log[i] != cyc_a[i] + ((cyc_a[i] > 8) ? 10 : 0)) bad++;
      end
    end else begin
      bad = 1;
    end
    checkOutput("ena_stream_diffs", bad, 0);

    // Rate write on the same edge as tick 2: that tick still uses rate 0.
    writeRate(0, 8'd0);
    writeRate(1, 8'd0);
    writeRate(7, 8'd0);
    startRun(8'd0, 8'd4);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd255;
    @(posedge clk); #1;
    wr_en = 1'b0;
    waitDone(100);
    checkOutput("wr_tick_count", spk_log.size(), 4);
    checkOutput("wr_ch0_total", countCh(0), 1);
    if (spk_log.size() == 4) begin
      checkOutput("wr_tick2_old_rate", int'(spk_log[1][0]), 0);
      checkOutput("wr_tick3", int'(spk_log[2][0]), 0);
      checkOutput("wr_tick4", int'(spk_log[3][0]), 1);
    end

    // Asynchronous reset in the middle of a run.
    writeRate(0, 8'd128);
    writeRate(7, 8'd255);
    startRun(8'd0, 8'd100);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_tick", int'(tick), 0);
    checkOutput("rst_spikes", int'(spikes), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    startRun(8'd0, 8'd8);
    waitDone(100);
    checkOutput("post_rst_ticks", spk_log.size(), 8);
    checkOutput("post_rst_ch0_rate_cleared", countCh(0), 0);
    checkOutput("post_rst_ch7_rate_cleared", countCh(7), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global guard so a stuck design can never hang the run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Rate-codes per-channel 8-bit intensities into parallel spike trains for the LIF neuron's dedicated spike inputs. It is the input-side counterpart of the neuron, which consumes spikes and emits spikes. Each channel has a rate register. A phase accumulator per channel produces a carry-out spike once per timestep tick. A run lasts a programmed number of ticks and ends with a done indication.

## Interface
- `CHANNELS`, 8, number of spike channels; width of the neuron input bus.
- `PRESCALE_W`, 8, width of the clocks-per-tick prescaler.
- `AW`, `$clog2(CHANNELS)`, rate-register address width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design enable; low freezes the run.
- `wr_en`  in  1  rate-register write strobe.
- `wr_addr`  in  AW  channel to write.
- `wr_data`  in  8  rate value, 0..255.
- `prescale`  in  PRESCALE_W  tick period minus 1, latched at start.
- `window`  in  8  ticks per run, latched at start; 0 means 256.
- `start`  in  1  run request pulse.
- `busy`  out  1  high while RUN.
- `done`  out  1  high while DONE.
- `tick`  out  1  one-clock pulse per emitted timestep.
- `spikes`  out  CHANNELS  registered spike vector; valid only while `tick`=1, zero otherwise.

## Operation
- States:
  - IDLE: reset state.
  - IDLE/DONE -> RUN on `start`; `start` is ignored in RUN.
  - RUN -> DONE after the `window`-th tick.
- On an accepted start:
  - latch `prescale` and `window`;
  - clear prescaler, tick counter and all accumulators;
  - clear `done`.
- Prescaler in RUN counts 0..prescale_q. A tick fires when the count equals prescale_q, then the count wraps to 0.
- On each tick, per channel c:
  - sum = acc[c] + rate[c], 9-bit;
  - acc[c] <= sum[7:0];
  - spikes[c] <= sum[8].
- Spike count over N ticks = floor(N·rate/256). rate 0 never spikes; rate 255 spikes 255 times in 256 ticks.
- Rate writes:
  - accepted in any state, including when `ena`=0;
  - a write coinciding with a tick: the tick uses the old rate, and the new rate applies from the next tick.
- `ena`=0 in RUN:
  - prescaler, tick counter and accumulators hold;
  - `tick` and `spikes` forced to 0;
  - resumes exactly where it stopped.
- Reset mid-run: immediate return to IDLE with every output 0. Rates clear to 0.

## Timing
- Reset values: `busy`=0, `done`=0, `tick`=0, `spikes`=0, rates=0, state IDLE.
- `start` sampled at edge E0 enters RUN at E0; `busy`=1 from E0.
- First tick is registered at edge E(prescale_q+1). Ticks repeat every prescale_q+1 clocks while `ena`=1. With prescale_q=0 there is a tick every clock.
- `spikes` and `tick` are registered: visible the cycle after the tick edge, for exactly one clock.
- The edge registering the final tick also enters DONE. `done`=1 and `busy`=0 in the same cycle as the final `spikes`.
- `done` holds until the next accepted `start` or reset.
- Back-to-back runs: `start` in DONE clears `done` at that edge, with no idle cycle.

## Configuration
- `SPIKE_ENC_STOCHASTIC_EN` undefined: deterministic accumulator encoding as above.
- `SPIKE_ENC_STOCHASTIC_EN` defined: accumulators are replaced by a stochastic source.
  - Source: one 16-bit Galois LFSR, taps 0xB400.
  - Seed 0xACE1 at reset and at each accepted start.
  - The LFSR advances once per tick, after sampling.
  - Spike rule: spikes[c] = (rotl(lfsr,c)[7:0] < rate[c]).
  - Handshake, timing, `ena` behaviour and window counting are unchanged.

## Structure
- Shared package `spike_enc_pkg`:
  - state enum IDLE/RUN/DONE;
  - LFSR seed and tap constants;
  - rate width constant (8).
- Sub-module `spike_phase_acc`:
  - one channel's accumulator or comparator, covering both compile variants;
  - inputs: rate, tick enable, clear;
  - output: spike bit;
  - instantiated CHANNELS times in a generate loop.
- Top level holds the FSM, prescaler, tick counter, rate register file and output registers.

## Test plan
- Reset, no stimulus for 20 clocks -> all outputs 0. `start` with all rates 0, window=4 -> 4 `tick` pulses, `spikes`=0, then `done`=1.
- rate[0]=128, rate[1]=64, prescale=0, window=8 -> ch0 spikes on ticks 2,4,6,8; ch1 on ticks 4,8; `done` asserts in the cycle of tick 8.
- rate[7]=255, window=0 (256 ticks), prescale=3 -> ticks every 4 clocks, 255 spikes on ch7, run lasts 1024 clocks.
- Deassert `ena` for 10 clocks mid-run, then reassert -> tick/spike sequence identical to an uninterrupted run, shifted by 10 clocks. A second `start` during RUN is ignored.
- Write rate[0] 0->255 on the same cycle as a tick -> that tick uses 0, later ticks use 255. Assert `rst_n`=0 mid-run -> outputs 0 immediately, state IDLE.
- With `SPIKE_ENC_STOCHASTIC_EN`: rate[0]=255 over 256 ticks -> 255 spikes. Two runs with identical programming -> bit-identical spike streams (reseeded at start).
